jed_fuse_loader: RTL and testbench



---
 rtl/jed_fuse_loader_pkg.sv | 37 +++
 rtl/jed_fuse_loader.sv | 183 ++++++++++++++++++
 tb/tb_jed_fuse_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jed_fuse_loader_pkg.sv
// Shared types and ASCII/error constants for the streaming JEDEC fuse loader.
// Pure definitions: no logic and no timing of its own.
package gal_jed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSTART,
    S_L_ADDR,
    S_L_BITS,
    S_F_VAL,
    S_SKIP,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [7:0] CH_STX  = 8'h02;
  localparam logic [7:0] CH_ETX  = 8'h03;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_F    = 8'h46;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR  = 2'd1;
  localparam logic [1:0] ERR_ADDR_OVF  = 2'd2;
  localparam logic [1:0] ERR_ETX_FIELD = 2'd3;

  localparam int GAL22V10_NUM_FUSES = 5892;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h09);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/jed_fuse_loader.sv
// Streaming JEDEC parser: one ASCII byte per cycle into a flat fuse vector; results visible the
// cycle after the byte is accepted. in_ready is high whenever out of reset; there is no backpressure.
module jed_fuse_loader
  import gal_jed_pkg::*;
#(
  parameter int NUM_FUSES = GAL22V10_NUM_FUSES,
  parameter int ADDR_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_FUSES-1:0] fuses,
  output logic                 fuses_valid,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam int AW4 = ADDR_W + 4;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 ovf_q, ovf_d;
  logic                 has_dig_q, has_dig_d;
  logic                 f_seen_q, f_seen_d;
  logic [NUM_FUSES-1:0] fuses_q, fuses_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 rdy_q;

  logic                 acc;
  logic [AW4-1:0]       addr_dec;
  logic                 raise;
  logic [1:0]           raise_code;

  assign acc      = in_valid && rdy_q;
  // Decimal accumulate at 4 extra bits so addr*10+9 can never wrap before the range check.
  assign addr_dec = ({4'b0000, addr_q} * AW4'(10)) + AW4'(in_data[3:0]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ovf_d      = ovf_q;
    has_dig_d  = has_dig_q;
    f_seen_d   = f_seen_q;
    fuses_d    = fuses_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    err_d      = err_q;
    code_d     = code_q;
    raise      = 1'b0;
    raise_code = ERR_NONE;

    if (acc) begin
      if (in_data == CH_STX) begin
        state_d = S_FSTART;
        addr_d  = '0;
        ovf_d   = 1'b0;
        fuses_d = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        busy_d  = 1'b1;
      end else begin
        case (state_q)
          S_FSTART: begin
            if (in_data == CH_L) begin
              state_d   = S_L_ADDR;
              addr_d    = '0;
              ovf_d     = 1'b0;
              has_dig_d = 1'b0;
            end else if (in_data == CH_F) begin
              state_d  = S_F_VAL;
              f_seen_d = 1'b0;
            end else if (in_data == CH_ETX) begin
              state_d = S_DONE;
              valid_d = 1'b1;
              busy_d  = 1'b0;
            end else if (!is_ws(in_data) && in_data != CH_STAR) begin
              state_d = S_SKIP;
            end
          end
          S_L_ADDR: begin
            if (in_data == CH_ETX) begin
              raise = 1'b1; raise_code = ERR_ETX_FIELD;
            end else if (is_digit(in_data)) begin
              addr_d    = addr_dec[ADDR_W-1:0];
              has_dig_d = 1'b1;
              if (addr_dec > AW4'(NUM_FUSES - 1)) ovf_d = 1'b1;
            end else if (is_ws(in_data) && has_dig_q) begin
              state_d = S_L_BITS;
            end else begin
              raise = 1'b1; raise_code = ERR_BAD_CHAR;
            end
          end
          S_L_BITS: begin
            if (in_data == CH_ETX) begin
              raise = 1'b1; raise_code = ERR_ETX_FIELD;
            end else if (in_data == 8'h30 || in_data == 8'h31) begin
              if (ovf_q || int'(addr_q) >= NUM_FUSES) begin
                raise = 1'b1; raise_code = ERR_ADDR_OVF;
              end else begin
                fuses_d[addr_q] = in_data[0];
                addr_d          = addr_q + 1'b1;
              end
            end else if (in_data == CH_STAR) begin
              state_d = S_FSTART;
            end else if (!is_ws(in_data)) begin
              raise = 1'b1; raise_code = ERR_BAD_CHAR;
            end
          end
          S_F_VAL: begin
            if (in_data == CH_ETX) begin
              raise = 1'b1; raise_code = ERR_ETX_FIELD;
            end else if (!f_seen_q && (in_data == 8'h30 || in_data == 8'h31)) begin
              fuses_d  = {NUM_FUSES{in_data[0]}};
              f_seen_d = 1'b1;
            end else if (f_seen_q && in_data == CH_STAR) begin
              state_d = S_FSTART;
            end else if (!is_ws(in_data)) begin
              raise = 1'b1; raise_code = ERR_BAD_CHAR;
            end
          end
          S_SKIP: begin
            if (in_data == CH_ETX) begin
              raise = 1'b1; raise_code = ERR_ETX_FIELD;
            end else if (in_data == CH_STAR) begin
              state_d = S_FSTART;
            end
          end
          default: ;
        endcase
      end
    end

    if (raise) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      code_d  = raise_code;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      has_dig_q <= 1'b0;
      f_seen_q  <= 1'b0;
      fuses_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      has_dig_q <= has_dig_d;
      f_seen_q  <= f_seen_d;
      fuses_q   <= fuses_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      code_q    <= code_d;
      rdy_q     <= 1'b1;
    end
  end

  assign in_ready    = rdy_q;
  assign fuses       = fuses_q;
  assign fuses_valid = valid_q;
  assign busy        = busy_q;
  assign error       = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_jed_fuse_loader.sv
// Directed-vector bench for jed_fuse_loader: streams small JEDEC fragments and checks
// fuse contents, completion, busy and error reporting against hand-computed values.
module tb_jed_fuse_loader;

  localparam int NF = 5892;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NF-1:0] fuses;
  logic          fuses_valid;
  logic          busy;
  logic          error;
  logic [1:0]    err_code;

  int vec_cnt = 0;
  int err_cnt = 0;

  jed_fuse_loader #(.NUM_FUSES(NF), .ADDR_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fuses(fuses), .fuses_valid(fuses_valid),
    .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vec_cnt++;
    if (fuses !== '0) begin err_cnt++; $display("FAIL rst_fuses got %0d ones want 0", $countones(fuses)); end
    vec_cnt++;
    if ({fuses_valid, busy, error, err_code} !== 5'b0) begin
      err_cnt++; $display("FAIL rst_flags got %b want 00000", {fuses_valid, busy, error, err_code});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_l_field;
    logic [NF-1:0] exp_f;
    exp_f = '0; exp_f[44] = 1'b1; exp_f[46] = 1'b1;
    send_byte(8'h02);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL l_busy_after_stx got %b want 1", busy); end
    send_str("L0044 ");
    in_data = "1"; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (fuses !== '0) begin err_cnt++; $display("FAIL l_idle_valid_low got %0d ones want 0", $countones(fuses)); end
    send_str("1 0 1*");
    vec_cnt++;
    if (fuses_valid !== 1'b0) begin err_cnt++; $display("FAIL l_valid_early got %b want 0", fuses_valid); end
    send_byte(8'h03);
    vec_cnt++;
    if (fuses !== exp_f) begin
      err_cnt++; $display("FAIL l_fuses got 44..46=%b%b%b ones=%0d want 101 ones=2", fuses[44], fuses[45], fuses[46], $countones(fuses));
    end
    vec_cnt++;
    if ({fuses_valid, busy, error} !== 3'b100) begin
      err_cnt++; $display("FAIL l_done got valid/busy/err=%b want 100", {fuses_valid, busy, error});
    end
  endtask

  task automatic test_restart;
    send_byte(8'h02);
    vec_cnt++;
    if ({fuses_valid, busy} !== 2'b01 || fuses !== '0) begin
      err_cnt++; $display("FAIL restart got valid/busy=%b ones=%0d want 01 ones=0", {fuses_valid, busy}, $countones(fuses));
    end
    send_byte(8'h03);
  endtask

  task automatic test_f_then_l;
    logic [NF-1:0] exp_f;
    exp_f = '1; exp_f[5891] = 1'b0;
    send_byte(8'h02);
    send_str("F1*L5891 0*");
    send_byte(8'h03);
    vec_cnt++;
    if (fuses !== exp_f) begin
      err_cnt++; $display("FAIL f_fill got ones=%0d f5891=%b want ones=5891 f5891=0", $countones(fuses), fuses[5891]);
    end
    vec_cnt++;
    if ({fuses_valid, error} !== 2'b10) begin err_cnt++; $display("FAIL f_done got valid/err=%b want 10", {fuses_valid, error}); end
  endtask

  task automatic test_addr_overflow;
    send_byte(8'h02);
    send_str("L5891 1");
    vec_cnt++;
    if (error !== 1'b0 || fuses[5891] !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_last_ok got err=%b f5891=%b want 0 1", error, fuses[5891]);
    end
    send_str("1");
    vec_cnt++;
    if ({error, err_code, busy, fuses_valid} !== 5'b11000) begin
      err_cnt++; $display("FAIL ovf_err got err/code/busy/valid=%b want 11000", {error, err_code, busy, fuses_valid});
    end
    send_str("*");
    send_byte(8'h03);
    vec_cnt++;
    if ({error, err_code, fuses_valid} !== 4'b1100) begin
      err_cnt++; $display("FAIL ovf_held got err/code/valid=%b want 1100", {error, err_code, fuses_valid});
    end
    send_byte(8'h02);
    send_str("L99999 0");
    vec_cnt++;
    if ({error, err_code} !== 3'b110) begin err_cnt++; $display("FAIL ovf_digits got err/code=%b want 110", {error, err_code}); end
  endtask

  task automatic test_bad_char;
    send_byte(8'h02);
    send_str("L12");
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL bad_pre got err=%b want 0", error); end
    send_str("X");
    vec_cnt++;
    if ({error, err_code, busy} !== 4'b1010) begin
      err_cnt++; $display("FAIL bad_char got err/code/busy=%b want 1010", {error, err_code, busy});
    end
  endtask

  task automatic test_etx_in_field;
    send_byte(8'h02);
    send_str("L10 1");
    send_byte(8'h03);
    vec_cnt++;
    if ({error, err_code, fuses_valid, fuses[10]} !== 5'b11101) begin
      err_cnt++; $display("FAIL etx_field got err/code/valid/f10=%b want 11101", {error, err_code, fuses_valid, fuses[10]});
    end
  endtask

  task automatic test_skip_fields;
    logic [NF-1:0] exp_f;
    exp_f = '0; exp_f[3] = 1'b1;
    send_byte(8'h02);
    vec_cnt++;
    if ({error, err_code} !== 3'b000) begin err_cnt++; $display("FAIL skip_stx_clear got err/code=%b want 000", {error, err_code}); end
    send_str("QF5892*G0*\r\nL3 1*");
    send_byte(8'h03);
    vec_cnt++;
    if (fuses !== exp_f || {fuses_valid, error} !== 2'b10) begin
      err_cnt++; $display("FAIL skip got ones=%0d f3=%b valid/err=%b want ones=1 f3=1 10", $countones(fuses), fuses[3], {fuses_valid, error});
    end
  endtask

  task automatic test_reset_mid_field;
    string s;
    int idx;
    int cyc;
    s = "L0100 1101";
    send_byte(8'h02);
    idx = 0;
    cyc = 0;
    while (idx < s.len() && cyc < 200) begin
      in_data  = s[idx];
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (in_valid) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    vec_cnt++;
    if (idx != s.len()) begin err_cnt++; $display("FAIL rmid_stream got %0d bytes want %0d", idx, s.len()); end
    vec_cnt++;
    if ({fuses[103:100], busy} !== 5'b10111) begin
      err_cnt++; $display("FAIL rmid_partial got f103..100/busy=%b want 10111", {fuses[103:100], busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (fuses !== '0 || {in_ready, fuses_valid, busy, error, err_code} !== 6'b0) begin
      err_cnt++; $display("FAIL rmid_async got ones=%0d rdy/valid/busy/err/code=%b want 0 000000",
                          $countones(fuses), {in_ready, fuses_valid, busy, error, err_code});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [NF-1:0] exp_f;
    logic [NF-1:0] first;
    exp_f = '0; exp_f[44] = 1'b1; exp_f[46] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h02);
      send_str("L0044 1 0 1*");
      send_byte(8'h03);
      vec_cnt++;
      if (fuses !== exp_f || fuses_valid !== 1'b1) begin
        err_cnt++; $display("FAIL b2b_run%0d got ones=%0d valid=%b want ones=2 valid=1", r, $countones(fuses), fuses_valid);
      end
      if (r == 0) first = fuses;
    end
    vec_cnt++;
    if (fuses !== first) begin err_cnt++; $display("FAIL b2b_same got ones=%0d want ones=%0d", $countones(fuses), $countones(first)); end
  endtask

  initial begin
    test_reset;
    test_l_field;
    test_restart;
    test_f_then_l;
    test_addr_overflow;
    test_bad_char;
    test_etx_in_field;
    test_skip_fields;
    test_reset_mid_field;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
